// File: rtl/axi_interconnect_pkg.sv
// Shared types for the AXI interconnect address path: decode rules, routed
// request payload and router state encoding.
package axi_interconnect_pkg;

    localparam int unsigned ADDR_WIDTH    = 32;
    localparam int unsigned SEL_WIDTH     = 1;
    localparam int unsigned AXI_LEN_WIDTH = 8;

    // One address window; bounds are inclusive.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] start_addr;
        logic [ADDR_WIDTH-1:0] end_addr;
        logic [SEL_WIDTH-1:0]  slave;
    } rule_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]    addr;
        logic [AXI_LEN_WIDTH-1:0] len;
        logic [SEL_WIDTH-1:0]     sel;
        logic                     err;
    } route_t;

    typedef enum logic {
        ROUTER_IDLE   = 1'b0,
        ROUTER_LOCKED = 1'b1
    } router_state_e;

endpackage : axi_interconnect_pkg

// File: rtl/addr_rule_decoder.sv
// Combinational priority address decoder: lowest-index matching rule wins,
// no match flags a decode error with slave index 0.
module addr_rule_decoder
    import axi_interconnect_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned NumRules  = 2,
    parameter int unsigned SelWidth  = 1,
    parameter logic [AddrWidth-1:0] RuleStart [NumRules] = '{32'h0000_0000, 32'h0002_0000},
    parameter logic [AddrWidth-1:0] RuleEnd   [NumRules] = '{32'h0001_FFFF, 32'h0002_FFFF},
    parameter int unsigned          RuleSlave [NumRules] = '{0, 1}
) (
    input  logic [AddrWidth-1:0] addr_i,
    output logic [SelWidth-1:0]  sel_o,
    output logic                 err_o
);

    rule_t rules [NumRules];

    for (genvar r = 0; r < NumRules; r++) begin : g_rules
        assign rules[r] = '{
            start_addr: ADDR_WIDTH'(RuleStart[r]),
            end_addr:   ADDR_WIDTH'(RuleEnd[r]),
            slave:      SEL_WIDTH'(RuleSlave[r])
        };
    end

    logic [ADDR_WIDTH-1:0] addr;
    logic                  hit;

    assign addr = ADDR_WIDTH'(addr_i);

    // First hit in index order claims the request.
    always_comb begin
        sel_o = '0;
        err_o = 1'b1;
        hit   = 1'b0;
        for (int i = 0; i < NumRules; i++) begin
            if (!hit && addr >= rules[i].start_addr && addr <= rules[i].end_addr) begin
                hit   = 1'b1;
                err_o = 1'b0;
                sel_o = SelWidth'(rules[i].slave);
            end
        end
    end

endmodule : addr_rule_decoder

// File: rtl/axi_addr_router.sv
// Registered address-channel router: decodes the target slave, holds one
// request in an output register and only switches target once idle.
module axi_addr_router
    import axi_interconnect_pkg::*;
#(
    parameter int unsigned NumSlaves = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned NumRules  = 2,
    parameter logic [AddrWidth-1:0] RuleStart [NumRules] = '{32'h0000_0000, 32'h0002_0000},
    parameter logic [AddrWidth-1:0] RuleEnd   [NumRules] = '{32'h0001_FFFF, 32'h0002_FFFF},
    parameter int unsigned          RuleSlave [NumRules] = '{0, 1},
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned SelWidth = (NumSlaves > 1) ? $clog2(NumSlaves) : 1,
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [AddrWidth-1:0] s_addr_i,
    input  logic [7:0]           s_len_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [AddrWidth-1:0] m_addr_o,
    output logic [7:0]           m_len_o,
    output logic [SelWidth-1:0]  m_sel_o,
    output logic                 m_err_o,
    input  logic                 cmpl_i,
    output logic [CntWidth-1:0]  outstanding_o,
    output logic                 underflow_o
);

    logic [SelWidth-1:0] dec_sel;
    logic                dec_err;

    addr_rule_decoder #(
        .AddrWidth (AddrWidth),
        .NumRules  (NumRules),
        .SelWidth  (SelWidth),
        .RuleStart (RuleStart),
        .RuleEnd   (RuleEnd),
        .RuleSlave (RuleSlave)
    ) u_decoder (
        .addr_i (s_addr_i),
        .sel_o  (dec_sel),
        .err_o  (dec_err)
    );

    router_state_e       state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [SelWidth-1:0] lock_sel_q, lock_sel_d;
    logic                lock_err_q, lock_err_d;
    route_t              route_q, route_d;
    logic                valid_q, valid_d;
    logic                underflow_q, underflow_d;

    logic allowed;
    logic accept;
    logic retire;

    // A locked router only admits more traffic to the same target, and only
    // while there is room in the outstanding budget.
    always_comb begin
        allowed = 1'b1;
        if (state_q == ROUTER_LOCKED) begin
            allowed = (dec_err == lock_err_q) && (dec_sel == lock_sel_q)
                   && (cnt_q < CntWidth'(MaxOutstanding));
        end
    end

    assign s_ready_o = allowed && (!valid_q || m_ready_i);
    assign accept    = s_valid_i && s_ready_o;
    assign retire    = cmpl_i && (cnt_q != '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lock_sel_d  = lock_sel_q;
        lock_err_d  = lock_err_q;
        route_d     = route_q;
        valid_d     = valid_q;
        underflow_d = underflow_q;

        if (accept) begin
            route_d.addr = ADDR_WIDTH'(s_addr_i);
            route_d.len  = AXI_LEN_WIDTH'(s_len_i);
            route_d.sel  = SEL_WIDTH'(dec_sel);
            route_d.err  = dec_err;
            valid_d      = 1'b1;
            lock_sel_d   = dec_sel;
            lock_err_d   = dec_err;
        end else if (m_ready_i) begin
            valid_d = 1'b0;
        end

        // A completion with nothing outstanding is a protocol error upstream.
        if (cmpl_i && (cnt_q == '0)) begin
            underflow_d = 1'b1;
        end

        unique case ({accept, retire})
            2'b10:   cnt_d = cnt_q + CntWidth'(1);
            2'b01:   cnt_d = cnt_q - CntWidth'(1);
            default: cnt_d = cnt_q;
        endcase

        state_d = (cnt_d == '0) ? ROUTER_IDLE : ROUTER_LOCKED;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ROUTER_IDLE;
            cnt_q       <= '0;
            lock_sel_q  <= '0;
            lock_err_q  <= 1'b0;
            route_q     <= '0;
            valid_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lock_sel_q  <= lock_sel_d;
            lock_err_q  <= lock_err_d;
            route_q     <= route_d;
            valid_q     <= valid_d;
            underflow_q <= underflow_d;
        end
    end

    assign m_valid_o     = valid_q;
    assign m_addr_o      = AddrWidth'(route_q.addr);
    assign m_len_o       = 8'(route_q.len);
    assign m_sel_o       = SelWidth'(route_q.sel);
    assign m_err_o       = route_q.err;
    assign outstanding_o = cnt_q;
    assign underflow_o   = underflow_q;

endmodule : axi_addr_router

// File: tb/tb_axi_addr_router.sv
// Bench for axi_addr_router: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_axi_addr_router;

    localparam int NS   = 2;
    localparam int MAXO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [31:0] s_addr_i;
    logic [7:0]  s_len_i;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [31:0] m_addr_o;
    logic [7:0]  m_len_o;
    logic [0:0]  m_sel_o;
    logic        m_err_o;
    logic        cmpl_i;
    logic [2:0]  outstanding_o;
    logic        underflow_o;

    axi_addr_router dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .s_valid_i     (s_valid_i),
        .s_ready_o     (s_ready_o),
        .s_addr_i      (s_addr_i),
        .s_len_i       (s_len_i),
        .m_valid_o     (m_valid_o),
        .m_ready_i     (m_ready_i),
        .m_addr_o      (m_addr_o),
        .m_len_o       (m_len_o),
        .m_sel_o       (m_sel_o),
        .m_err_o       (m_err_o),
        .cmpl_i        (cmpl_i),
        .outstanding_o (outstanding_o),
        .underflow_o   (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: address map as plain tables, a target id where
    // NS stands for the decode-error responder.
    int unsigned r_start [2] = '{32'h0000_0000, 32'h0002_0000};
    int unsigned r_end   [2] = '{32'h0001_FFFF, 32'h0002_FFFF};
    int          r_slave [2] = '{0, 1};

    int          mcnt;
    int          mlock;
    bit          mv;
    bit          muf;
    logic [31:0] maddr;
    logic [7:0]  mlen;
    int          mtgt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_target(input logic [31:0] a);
        for (int i = 0; i < 2; i++) begin
            if (a >= r_start[i] && a <= r_end[i]) return r_slave[i];
        end
        return NS;
    endfunction

    task automatic model_reset();
        mcnt  = 0;
        mlock = 0;
        mv    = 1'b0;
        muf   = 1'b0;
        maddr = '0;
        mlen  = '0;
        mtgt  = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".m_valid"}, m_valid_o, mv);
        check({tag, ".m_addr"}, m_addr_o, maddr);
        check({tag, ".m_len"}, m_len_o, mlen);
        check({tag, ".m_sel"}, m_sel_o, (mtgt == NS) ? 0 : mtgt);
        check({tag, ".m_err"}, m_err_o, mtgt == NS);
        check({tag, ".outstanding"}, outstanding_o, mcnt);
        check({tag, ".underflow"}, underflow_o, muf);
    endtask

    // One clock cycle: called just after a falling edge, returns on the next.
    task automatic step(input string tag, input bit v, input logic [31:0] a,
                        input logic [7:0] l, input bit rdy, input bit c);
        int  t;
        bit  allow;
        bit  exp_rdy;
        bit  acc;
        s_valid_i = v;
        s_addr_i  = a;
        s_len_i   = l;
        m_ready_i = rdy;
        cmpl_i    = c;
        #1;
        t       = ref_target(a);
        allow   = (mcnt == 0) || (t == mlock && mcnt < MAXO);
        exp_rdy = allow && (!mv || rdy);
        check({tag, ".s_ready"}, s_ready_o, exp_rdy);
        acc = v && exp_rdy;
        if (acc) begin
            mv    = 1'b1;
            maddr = a;
            mlen  = l;
            mtgt  = t;
            mlock = t;
        end else if (rdy) begin
            mv = 1'b0;
        end
        if (c && mcnt == 0) muf = 1'b1;
        mcnt = mcnt + (acc ? 1 : 0) - ((c && mcnt > 0) ? 1 : 0);
        @(posedge clk_i);
        #1;
        check_outputs(tag);
        @(negedge clk_i);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 8 && mcnt > 0; i++) step(tag, 1'b0, 32'h0, 8'h0, 1'b1, 1'b1);
    endtask

    initial begin
        logic [31:0] a;
        rst_ni    = 1'b0;
        s_valid_i = 1'b0;
        s_addr_i  = '0;
        s_len_i   = '0;
        m_ready_i = 1'b0;
        cmpl_i    = 1'b0;
        model_reset();
        #1;
        check_outputs("reset");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single request to slave 0.
        step("basic", 1'b1, 32'h0000_1000, 8'h03, 1'b1, 1'b0);
        check("basic.sel0", m_sel_o, 1'b0);
        check("basic.cnt1", outstanding_o, 3'd1);
        drain("basic_drain");

        // Target switch must wait for the earlier transaction to retire.
        step("switch_a", 1'b1, 32'h0002_0000, 8'h01, 1'b1, 1'b0);
        check("switch_a.sel1", m_sel_o, 1'b1);
        step("switch_stall", 1'b1, 32'h0001_FFFC, 8'h02, 1'b1, 1'b0);
        check("switch_stall.ready0", s_ready_o, 1'b0);
        step("switch_same_cyc", 1'b1, 32'h0001_FFFC, 8'h02, 1'b1, 1'b1);
        step("switch_b", 1'b1, 32'h0001_FFFC, 8'h02, 1'b1, 1'b0);
        check("switch_b.sel0", m_sel_o, 1'b0);
        drain("switch_drain");

        // Unmapped address locks like a slave.
        step("decerr", 1'b1, 32'h0003_0000, 8'h00, 1'b1, 1'b0);
        check("decerr.err", m_err_o, 1'b1);
        step("decerr_stall", 1'b1, 32'h0000_0000, 8'h00, 1'b1, 1'b0);
        step("decerr_cmpl", 1'b0, 32'h0000_0000, 8'h00, 1'b1, 1'b1);
        step("decerr_after", 1'b1, 32'h0000_0000, 8'h07, 1'b1, 1'b0);
        drain("decerr_drain");

        // Outstanding limit.
        for (int i = 0; i < 5; i++) step("limit", 1'b1, 32'h100 * i, 8'(i), 1'b1, 1'b0);
        check("limit.cnt4", outstanding_o, 3'd4);
        step("limit_cmpl", 1'b1, 32'h0000_0400, 8'h04, 1'b1, 1'b1);
        step("limit_accept", 1'b1, 32'h0000_0400, 8'h04, 1'b1, 1'b0);
        check("limit.cnt_still4", outstanding_o, 3'd4);
        drain("limit_drain");

        // Back-pressure holds the output register.
        step("bp_load", 1'b1, 32'h0002_1234, 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("bp_hold", 1'b1, 32'h0002_2000, 8'h66, 1'b0, 1'b0);
        check("bp.addr_held", m_addr_o, 32'h0002_1234);
        step("bp_release", 1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        drain("bp_drain");

        // Completion with nothing outstanding, then reset during a stall.
        step("underflow", 1'b0, 32'h0, 8'h0, 1'b1, 1'b1);
        check("underflow.flag", underflow_o, 1'b1);
        step("rst_load", 1'b1, 32'h0000_8000, 8'h11, 1'b1, 1'b0);
        step("rst_stall", 1'b1, 32'h0000_8100, 8'h12, 1'b0, 1'b0);
        s_valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        step("post_rst_cmpl", 1'b0, 32'h0, 8'h0, 1'b1, 1'b1);

        // Random traffic biased towards rule boundaries.
        for (int n = 0; n < 500; n++) begin
            case ($urandom_range(0, 7))
                0: a = 32'h0000_0000;
                1: a = 32'h0001_FFFF;
                2: a = 32'h0002_0000;
                3: a = 32'h0002_FFFF;
                4: a = 32'h0003_0000;
                5: a = 32'hFFFF_FFFF;
                6: a = $urandom_range(0, 32'h0002_FFFF);
                default: a = $urandom;
            endcase
            step("rand", ($urandom % 4) != 0, a, 8'($urandom), ($urandom % 4) != 0,
                 (mcnt > 0) ? (($urandom % 3) == 0) : (($urandom % 40) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_axi_addr_router
